// File: rtl/tx_arbiter_pkg.sv
// Shared types for the inter-device tx arbiter: flit format, source and state
// encodings, and head/tail classification helpers.
package types;

  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_ACK, SRC_RETX, SRC_FWD} tx_src_t;
  typedef enum logic [1:0] {IDLE, LOCK_RETX, LOCK_FWD} tx_arb_state_t;

  function automatic logic flit_is_head(flit_t f);
    return f.head;
  endfunction

  function automatic logic flit_is_tail(flit_t f);
    return f.tail;
  endfunction

endpackage

// File: rtl/tx_arbiter_grant_comb.sv
// Pure combinational grant selection for tx_arbiter. Grants only a valid
// source; aged flags lift retx/fwd above ack.
module tx_arb_grant_comb
  import types::*;
(
  input  tx_arb_state_t state_i,
  input  logic          ack_v_i,
  input  logic          retx_v_i,
  input  logic          fwd_v_i,
  input  tx_src_t       rr_last_i,
  input  logic          retx_aged_i,
  input  logic          fwd_aged_i,
  output tx_src_t       grant_o
);

  tx_src_t rr_pick;
  logic    retx_hi, fwd_hi;

  always_comb begin
    grant_o = SRC_NONE;
    rr_pick = (rr_last_i == SRC_RETX) ? SRC_FWD : SRC_RETX;
    retx_hi = retx_v_i && retx_aged_i;
    fwd_hi  = fwd_v_i && fwd_aged_i;
    case (state_i)
      LOCK_RETX: begin
        if (retx_hi)       grant_o = SRC_RETX;
        else if (ack_v_i)  grant_o = SRC_ACK;
        else if (retx_v_i) grant_o = SRC_RETX;
      end
      LOCK_FWD: begin
        if (fwd_hi)        grant_o = SRC_FWD;
        else if (ack_v_i)  grant_o = SRC_ACK;
        else if (fwd_v_i)  grant_o = SRC_FWD;
      end
      default: begin
        if (retx_hi && fwd_hi)       grant_o = rr_pick;
        else if (retx_hi)            grant_o = SRC_RETX;
        else if (fwd_hi)             grant_o = SRC_FWD;
        else if (ack_v_i)            grant_o = SRC_ACK;
        else if (retx_v_i && fwd_v_i) grant_o = rr_pick;
        else if (retx_v_i)           grant_o = SRC_RETX;
        else if (fwd_v_i)            grant_o = SRC_FWD;
      end
    endcase
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbiter from ack / retransmit / forward queues onto the inter-device tx
// channel, keeping retx/fwd packets contiguous. TX_ARB_AGING_EN adds aging.
module tx_arbiter
  import types::*;
#(
  parameter int MAX_PKT_FLITS = 16,
  parameter int AGE_LIMIT     = 8
) (
  input  logic  nocclk,
  input  logic  rst,
  input  flit_t ack_flit,
  input  logic  ack_flit_valid,
  output logic  ack_flit_ready,
  input  flit_t retx_flit,
  input  logic  retx_flit_valid,
  output logic  retx_flit_ready,
  input  flit_t fwd_flit,
  input  logic  fwd_flit_valid,
  output logic  fwd_flit_ready,
  output flit_t flit_out,
  output logic  flit_out_valid,
  input  logic  flit_out_ready,
  output logic  lock_err,
  output logic  busy
);

  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);

  tx_arb_state_t   state_q, state_d;
  tx_src_t         rr_last_q, rr_last_d, grant;
  logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d, cnt_inc;
  flit_t           flit_out_q, pop_flit;
  logic            flit_out_valid_q, lock_err_q, lock_err_d;
  logic            load_en, pop, retx_pop, fwd_pop, src_pop;
  logic            retx_aged, fwd_aged;

  assign load_en = !flit_out_valid_q || flit_out_ready;

  tx_arb_grant_comb u_grant (
    .state_i    (state_q),
    .ack_v_i    (ack_flit_valid),
    .retx_v_i   (retx_flit_valid),
    .fwd_v_i    (fwd_flit_valid),
    .rr_last_i  (rr_last_q),
    .retx_aged_i(retx_aged),
    .fwd_aged_i (fwd_aged),
    .grant_o    (grant)
  );

  assign ack_flit_ready  = !rst && load_en && (grant == SRC_ACK);
  assign retx_flit_ready = !rst && load_en && (grant == SRC_RETX);
  assign fwd_flit_ready  = !rst && load_en && (grant == SRC_FWD);

  assign retx_pop = retx_flit_valid && retx_flit_ready;
  assign fwd_pop  = fwd_flit_valid && fwd_flit_ready;
  assign src_pop  = retx_pop || fwd_pop;
  assign pop      = src_pop || (ack_flit_valid && ack_flit_ready);

  always_comb begin
    case (grant)
      SRC_ACK:  pop_flit = ack_flit;
      SRC_RETX: pop_flit = retx_flit;
      SRC_FWD:  pop_flit = fwd_flit;
      default:  pop_flit = '0;
    endcase
  end

  // Ack pops never touch the lock; only retx/fwd pops move the FSM.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    flit_cnt_d = flit_cnt_q;
    lock_err_d = 1'b0;
    cnt_inc    = (flit_cnt_q == CNT_W'(MAX_PKT_FLITS)) ? flit_cnt_q : flit_cnt_q + 1'b1;
    if (src_pop) begin
      if (state_q == IDLE) begin
        rr_last_d = grant;
        if (flit_is_head(pop_flit) && !flit_is_tail(pop_flit)) begin
          state_d    = (grant == SRC_RETX) ? LOCK_RETX : LOCK_FWD;
          flit_cnt_d = CNT_W'(1);
        end
      end else if (flit_is_tail(pop_flit)) begin
        state_d    = IDLE;
        flit_cnt_d = '0;
      end else if (cnt_inc == CNT_W'(MAX_PKT_FLITS)) begin
        state_d    = IDLE;
        flit_cnt_d = '0;
        lock_err_d = 1'b1;
      end else begin
        flit_cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      state_q          <= IDLE;
      rr_last_q        <= SRC_FWD;
      flit_cnt_q       <= '0;
      lock_err_q       <= 1'b0;
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      flit_cnt_q <= flit_cnt_d;
      lock_err_q <= lock_err_d;
      if (load_en) begin
        flit_out_valid_q <= pop;
        if (pop) flit_out_q <= pop_flit;
      end
    end
  end

`ifdef TX_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] retx_age_q, retx_age_d, fwd_age_q, fwd_age_d;

  // A source's packet is finished when its pop leaves the FSM in IDLE.
  always_comb begin
    retx_age_d = retx_age_q;
    fwd_age_d  = fwd_age_q;
    if (retx_pop) begin
      if (state_d == IDLE) retx_age_d = '0;
    end else if (retx_flit_valid && load_en && state_q != LOCK_FWD &&
                 retx_age_q != AGE_W'(AGE_LIMIT)) begin
      retx_age_d = retx_age_q + 1'b1;
    end
    if (fwd_pop) begin
      if (state_d == IDLE) fwd_age_d = '0;
    end else if (fwd_flit_valid && load_en && state_q != LOCK_RETX &&
                 fwd_age_q != AGE_W'(AGE_LIMIT)) begin
      fwd_age_d = fwd_age_q + 1'b1;
    end
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      retx_age_q <= '0;
      fwd_age_q  <= '0;
    end else begin
      retx_age_q <= retx_age_d;
      fwd_age_q  <= fwd_age_d;
    end
  end

  assign retx_aged = (retx_age_q == AGE_W'(AGE_LIMIT));
  assign fwd_aged  = (fwd_age_q == AGE_W'(AGE_LIMIT));
`else
  localparam int age_limit_unused = AGE_LIMIT;
  assign retx_aged = 1'b0;
  assign fwd_aged  = 1'b0;
`endif

  assign flit_out       = flit_out_q;
  assign flit_out_valid = flit_out_valid_q;
  assign lock_err       = lock_err_q;
  assign busy           = (state_q != IDLE) || flit_out_valid_q;

endmodule
